// File: rtl/rotary_decoder.sv
// Quadrature rotary-encoder front end: resynchronise, debounce, hysteresis
// filter, step/direction decode and a wrapping or saturating position count.
// All outputs are registered in the CLK domain.
module rotary_decoder #(
  parameter int unsigned DEB_CYC = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned POS_MAX = 255,
  parameter int unsigned WRAP    = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ROTA,
  input  logic             ROTB,
  input  logic             EN,
  input  logic             CLR,
  output logic             ROTAF,
  output logic             ROTBF,
  output logic             ROT_EVENT,
  output logic             ROT_LEFT,
  output logic [CNT_W-1:0] POS
);

  localparam int unsigned      CW   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNT_W-1:0] PMAX = CNT_W'(POS_MAX);

  // bit 1 = phase a, bit 0 = phase b (both active-high internally)
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       deb;
  logic             rotaf_q;
  logic             rise;
  logic [CNT_W-1:0] pos_nxt;

  // Two-flop resynchroniser on the inverted raw encoder pins
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {~ROTA, ~ROTB};
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_deb
    logic q;
    assign deb[g] = q;

    if (DEB_CYC == 0) begin : g_bypass
      // Debounce bypassed: plain register stage keeps latency uniform
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) q <= 1'b0;
        else        q <= sync2[g];
      end
    end else begin : g_count
      logic [CW-1:0] cnt;
      // Accept a new level only after DEB_CYC consecutive differing samples
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          q   <= 1'b0;
          cnt <= '0;
        end else if (sync2[g] == q) begin
          cnt <= '0;
        end else if (cnt == CW'(DEB_CYC - 1)) begin
          q   <= sync2[g];
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Hysteresis filter: each debounced phase pair moves only one output
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ROTAF <= 1'b0;
      ROTBF <= 1'b0;
    end else begin
      case (deb)
        2'b00:   ROTAF <= 1'b0;
        2'b01:   ROTBF <= 1'b0;
        2'b10:   ROTBF <= 1'b1;
        default: ROTAF <= 1'b1;
      endcase
    end
  end

  assign rise = ROTAF & ~rotaf_q;

  // Next position for one step in the current ROTBF direction
  always_comb begin
    pos_nxt = POS;
    if (ROTBF) begin
      if (POS == '0) pos_nxt = (WRAP != 0) ? PMAX : '0;
      else           pos_nxt = POS - CNT_W'(1);
    end else begin
      if (POS == PMAX) pos_nxt = (WRAP != 0) ? '0 : PMAX;
      else             pos_nxt = POS + CNT_W'(1);
    end
  end

  // Step decode on ROTAF rise; CLR wins over a coincident step for POS only
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rotaf_q   <= 1'b0;
      ROT_EVENT <= 1'b0;
      ROT_LEFT  <= 1'b0;
      POS       <= '0;
    end else begin
      rotaf_q   <= ROTAF;
      ROT_EVENT <= rise & EN;
      if (rise && EN) ROT_LEFT <= ROTBF;
      if (CLR)              POS <= '0;
      else if (rise && EN)  POS <= pos_nxt;
    end
  end

endmodule

// File: tb/tb_rotary_decoder.sv
// Bench for rotary_decoder: two instances (wrapping and saturating) share the
// same encoder stimulus and are compared against a phase-level reference model.
module tb_rotary_decoder;

  logic       clk = 1'b0;
  logic       rst_n, rota, rotb, en, clr;
  logic       af_w, bf_w, ev_w, left_w;
  logic       af_s, bf_s, ev_s, left_s;
  logic [3:0] pos_w, pos_s;

  int checks = 0;
  int errors = 0;

  // reference model state (phase-level view)
  int m_raf = 0, m_rbf = 0, m_left = 0, m_ev = 0, m_pw = 0, m_ps = 0;
  int cnt_w = 0, cnt_s = 0;

  always #5 clk = ~clk;

  rotary_decoder #(.DEB_CYC(4), .CNT_W(4), .POS_MAX(15), .WRAP(1)) u_wrap (
    .CLK(clk), .RST_N(rst_n), .ROTA(rota), .ROTB(rotb), .EN(en), .CLR(clr),
    .ROTAF(af_w), .ROTBF(bf_w), .ROT_EVENT(ev_w), .ROT_LEFT(left_w), .POS(pos_w));

  rotary_decoder #(.DEB_CYC(4), .CNT_W(4), .POS_MAX(15), .WRAP(0)) u_sat (
    .CLK(clk), .RST_N(rst_n), .ROTA(rota), .ROTB(rotb), .EN(en), .CLR(clr),
    .ROTAF(af_s), .ROTBF(bf_s), .ROT_EVENT(ev_s), .ROT_LEFT(left_s), .POS(pos_s));

  // event pulses are counted mid-cycle
  always @(negedge clk) begin
    if (ev_w === 1'b1) cnt_w++;
    if (ev_s === 1'b1) cnt_s++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input int b);
    rota = (a == 0);
    rotb = (b == 0);
  endtask

  // Phase-level rules: filter table, one step per filtered-A rise
  task automatic model_apply(input int a, input int b);
    int prev;
    prev = m_raf;
    case ({a[0], b[0]})
      2'b00: m_raf = 0;
      2'b01: m_rbf = 0;
      2'b10: m_rbf = 1;
      default: m_raf = 1;
    endcase
    if (prev == 0 && m_raf == 1 && en) begin
      m_ev++;
      m_left = m_rbf;
      if (m_left == 1) begin
        m_pw = (m_pw + 15) % 16;
        m_ps = (m_ps == 0) ? 0 : m_ps - 1;
      end else begin
        m_pw = (m_pw + 1) % 16;
        m_ps = (m_ps == 15) ? 15 : m_ps + 1;
      end
    end
  endtask

  task automatic set_phase(input int a, input int b, input int hold);
    drive(a, b);
    repeat (hold) tick();
    model_apply(a, b);
  endtask

  task automatic step_right();
    set_phase(0, 1, 10); set_phase(1, 1, 10); set_phase(1, 0, 10); set_phase(0, 0, 10);
  endtask

  task automatic step_left();
    set_phase(1, 0, 10); set_phase(1, 1, 10); set_phase(0, 1, 10); set_phase(0, 0, 10);
  endtask

  task automatic model_reset();
    m_raf = 0; m_rbf = 0; m_left = 0; m_pw = 0; m_ps = 0;
  endtask

  task automatic check_state(input string tag);
    checks++;
    if (af_w !== m_raf[0] || af_s !== m_raf[0]) begin
      errors++; $display("FAIL %s rotaf: got %b/%b expected %0d", tag, af_w, af_s, m_raf);
    end
    checks++;
    if (bf_w !== m_rbf[0] || bf_s !== m_rbf[0]) begin
      errors++; $display("FAIL %s rotbf: got %b/%b expected %0d", tag, bf_w, bf_s, m_rbf);
    end
    checks++;
    if (pos_w !== 4'(m_pw) || pos_s !== 4'(m_ps)) begin
      errors++; $display("FAIL %s pos: got %0d/%0d expected %0d/%0d", tag, pos_w, pos_s, m_pw, m_ps);
    end
    checks++;
    if (cnt_w != m_ev || cnt_s != m_ev) begin
      errors++; $display("FAIL %s events: got %0d/%0d expected %0d", tag, cnt_w, cnt_s, m_ev);
    end
    checks++;
    if (left_w !== m_left[0] || left_s !== m_left[0]) begin
      errors++; $display("FAIL %s rot_left: got %b/%b expected %0d", tag, left_w, left_s, m_left);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; drive(0, 0);
    repeat (3) tick();
    checks++;
    if ({af_w, bf_w, ev_w, left_w, pos_w, af_s, bf_s, ev_s, left_s, pos_s} !== '0) begin
      errors++; $display("FAIL reset_values: got %b/%b/%b/%b/%0d expected all 0", af_w, bf_w, ev_w, left_w, pos_w);
    end
    rst_n = 1'b1;
    repeat (10) tick();
    check_state("idle_after_reset");
  endtask

  task automatic test_right_step();
    set_phase(0, 1, 10);
    drive(1, 1);
    repeat (7) tick();
    checks++;
    if (ev_w !== 1'b0) begin errors++; $display("FAIL right_early: got %b expected 0", ev_w); end
    tick();
    checks++;
    if (ev_w !== 1'b1 || ev_s !== 1'b1) begin errors++; $display("FAIL right_latency: got %b/%b expected 1", ev_w, ev_s); end
    checks++;
    if (left_w !== 1'b0) begin errors++; $display("FAIL right_dir: got %b expected 0", left_w); end
    tick();
    checks++;
    if (ev_w !== 1'b0) begin errors++; $display("FAIL right_pulse_width: got %b expected 0", ev_w); end
    tick();
    model_apply(1, 1);
    set_phase(1, 0, 10); set_phase(0, 0, 10);
    check_state("right_step");
    checks++;
    if (pos_w !== 4'd1) begin errors++; $display("FAIL right_pos: got %0d expected 1", pos_w); end
  endtask

  task automatic test_left_step();
    step_left();
    check_state("left_step");
    checks++;
    if (left_w !== 1'b1 || pos_w !== 4'd0) begin
      errors++; $display("FAIL left_dir_pos: got %b/%0d expected 1/0", left_w, pos_w);
    end
  endtask

  task automatic test_glitch();
    drive(1, 0); repeat (3) tick();
    drive(0, 0); repeat (12) tick();
    check_state("glitch_a");
    drive(0, 1); repeat (3) tick();
    drive(0, 0); repeat (12) tick();
    check_state("glitch_b");
  endtask

  task automatic test_wrap_sat();
    step_left();
    check_state("wrap_below_zero");
    step_right();
    check_state("wrap_above_max");
    repeat (15) step_right();
    check_state("sat_reach_max");
    step_right();
    check_state("sat_at_max");
  endtask

  task automatic test_clr();
    clr = 1'b1; tick(); clr = 1'b0;
    m_pw = 0; m_ps = 0;
    check_state("clr_plain");
    repeat (7) step_right();
    check_state("pos_seven");
    set_phase(0, 1, 10);
    drive(1, 1);
    repeat (7) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    checks++;
    if (ev_w !== 1'b1 || pos_w !== 4'd0 || pos_s !== 4'd0) begin
      errors++; $display("FAIL clr_on_event: got ev=%b pos=%0d/%0d expected ev=1 pos=0", ev_w, pos_w, pos_s);
    end
    repeat (2) tick();
    model_apply(1, 1);
    m_pw = 0; m_ps = 0;
    set_phase(1, 0, 10); set_phase(0, 0, 10);
    check_state("clr_event_after");
  endtask

  task automatic test_enable();
    step_left();
    en = 1'b0;
    step_right();
    check_state("en_off_step");
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    set_phase(0, 1, 10); set_phase(1, 1, 10); set_phase(1, 0, 10);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({af_w, bf_w, ev_w, left_w, pos_w, af_s, bf_s, ev_s, left_s, pos_s} !== '0) begin
      errors++; $display("FAIL async_reset: got %b/%b/%b/%b/%0d expected all 0", af_w, bf_w, ev_w, left_w, pos_w);
    end
    tick(); tick();
    rst_n = 1'b1;
    model_reset();
    repeat (6) tick();
    checks++;
    if (bf_w !== 1'b0) begin errors++; $display("FAIL reacquire_early: got %b expected 0", bf_w); end
    tick();
    checks++;
    if (bf_w !== 1'b1 || bf_s !== 1'b1) begin errors++; $display("FAIL reacquire_edge7: got %b/%b expected 1", bf_w, bf_s); end
    repeat (6) tick();
    model_apply(1, 0);
    check_state("reacquire_10");
    set_phase(0, 0, 10);
  endtask

  task automatic test_random();
    int a, b, cur_a, cur_b, hold;
    cur_a = 0; cur_b = 0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) drive(1 - cur_a, cur_b);
        else                           drive(cur_a, 1 - cur_b);
        repeat ($urandom_range(1, 3)) tick();
        drive(cur_a, cur_b);
        repeat (2) tick();
      end
      a = $urandom_range(0, 1);
      b = $urandom_range(0, 1);
      en = ($urandom_range(0, 4) != 0);
      hold = $urandom_range(10, 14);
      drive(a, b);
      if ($urandom_range(0, 9) == 0) begin
        tick(); clr = 1'b1; tick(); clr = 1'b0;
        m_pw = 0; m_ps = 0;
        hold = hold - 2;
      end
      repeat (hold) tick();
      model_apply(a, b);
      cur_a = a; cur_b = b;
      check_state("random");
    end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_right_step();
    test_left_step();
    test_glitch();
    test_wrap_sat();
    test_clr();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
